instr_mem_sync: RTL and testbench
=================================

// Module: instr_mem_sync
// PURPOSE
//   Parametrised, synchronous, loadable instruction memory for the RISC core fetch stage.
//   Holds DEPTH words of DATA_W bits and returns one registered instruction per accepted fetch.
//   Supports pipeline stall and flush, plus a program-load write port.
//   Runs a hardware clear sweep after reset so that every unloaded location reads NOP_WORD.
// PARAMETERS
//   ADDR_W   6        fetch/load address width
//   DATA_W   16       instruction width
//   DEPTH    64       implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_W
//   NOP_WORD 16'h0000 value driven on instr at reset/flush; value written by the clear sweep
// PORTS
//   clk          in   1       single clock; all state is updated on the rising edge
//   rst          in   1       asynchronous, active-high reset
//   fetch_en     in   1       fetch request
//   fetch_addr   in   ADDR_W  fetch address (word index)
//   stall        in   1       hold instr/instr_valid; the fetch is not accepted
//   flush        in   1       kill the output instruction
//   ld_we        in   1       program-load write strobe
//   ld_addr      in   ADDR_W  load address
//   ld_data      in   DATA_W  load data
//   instr        out  DATA_W  registered instruction
//   instr_valid  out  1       instr holds a fetched word
//   ready        out  1       clear sweep done; fetches and loads are accepted
//   ld_err       out  1       one-cycle pulse: a load write was rejected
// BEHAVIOUR
//   Reset: asserting rst immediately forces the following, even mid-operation:
//     instr=NOP_WORD, instr_valid=0, ready=0, ld_err=0, FSM=INIT, clr_cnt=0.
//     Memory array contents are not reset directly; the INIT sweep rewrites them.
//   FSM states are INIT and RUN.
//     INIT: each cycle, mem[clr_cnt] <= NOP_WORD and clr_cnt increments.
//       When clr_cnt==DEPTH-1, the FSM goes to RUN and ready=1 from the next cycle.
//       INIT therefore takes exactly DEPTH cycles after rst deasserts.
//       fetch_en is ignored in INIT.
//       ld_we in INIT is dropped and ld_err pulses 1 cycle later.
//     RUN: terminal state; only rst leaves it.
//   Fetch (RUN only): priority order is flush, then stall, then fetch_en.
//     flush=1: next cycle instr=NOP_WORD and instr_valid=0; overrides stall and fetch_en.
//     stall=1 (and no flush): instr and instr_valid hold their values; fetch_en is ignored.
//     fetch_en=1: latency is 1 cycle.
//       instr <= (fetch_addr<DEPTH) ? mem[fetch_addr] : NOP_WORD.
//       instr_valid <= 1.
//     fetch_en=0: instr_valid <= 0; instr holds its value.
//   Load (RUN only):
//     ld_we=1 and ld_addr<DEPTH: mem[ld_addr] <= ld_data. stall and flush do not block loads.
//     ld_we=1 and ld_addr>=DEPTH: the write is dropped and ld_err pulses on the next cycle.
//   Same-cycle read and write to the same address: read-first.
//     instr gets the old word; the new word is visible from the next fetch.
//   Width rules:
//     Address comparison is unsigned, zero-extended.
//     No wrap-around; out-of-range addresses never alias onto valid locations.
// TESTING
//   T1 reset/init (DEPTH=64): release rst, hold fetch_en=1.
//      -> ready=0 for 64 cycles and instr_valid=0 throughout; ready=1 on cycle 65.
//      -> a fetch of addr 5 then returns 16'h0000 with instr_valid=1.
//   T2 load/fetch: load 0:B040, 1:B210, 2:C250, then fetch addr 0,1,2 on consecutive cycles.
//      -> instr = B040, B210, C250, one cycle after each request; instr_valid stays 1.
//   T3 stall/flush: fetch addr 1, then stall=1 for 3 cycles with fetch_en=1 addr 2.
//      -> instr holds B210 with instr_valid=1 during the stall.
//      -> flush=1 together with stall=1 gives instr=0000, instr_valid=0 next cycle.
//   T4 read-first: ld_we addr 3 data 1234 and fetch addr 3 in the same cycle, old value 0000.
//      -> instr=0000; a fetch of addr 3 on the next cycle -> 1234.
//   T5 errors (DEPTH=48): ld_we addr 50.
//      -> ld_err=1 for exactly 1 cycle; a fetch of addr 50 -> 0000; addr 50-48=2 is unchanged.
//      -> ld_we during INIT -> ld_err pulse, and the word stays NOP_WORD after INIT.
//   T6 async reset mid-run: assert rst between clock edges while instr_valid=1.
//      -> instr_valid=0 and ready=0 immediately; INIT re-runs; previously loaded words read 0000.

Source files
------------

// File: rtl/instr_mem_sync.sv
// Synchronous, loadable instruction memory for the fetch stage.
// After reset an INIT sweep writes NOP_WORD to every word. Then the RUN state
// serves fetches (flush > stall > fetch_en) and program-load writes.
module instr_mem_sync #(
    parameter int unsigned           ADDR_W   = 6,
    parameter int unsigned           DATA_W   = 16,
    parameter int unsigned           DEPTH    = 64,
    parameter logic [DATA_W-1:0]     NOP_WORD = DATA_W'(0)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              stall,
    input  logic              flush,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              ready,
    output logic              ld_err
);

    localparam int unsigned LAST_IDX = DEPTH - 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              fetch_in_range;
    logic              ld_in_range;
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0] instr_nxt;
    logic              instr_valid_nxt;
    logic              ready_nxt;
    logic              ld_err_nxt;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Unsigned, zero-extended range checks: out-of-range addresses never alias.
    always_comb begin
        fetch_in_range = (32'(fetch_addr) < DEPTH);
        ld_in_range    = (32'(ld_addr) < DEPTH);
        rd_word        = fetch_in_range ? mem[fetch_addr] : NOP_WORD;
    end

    // State register and registered outputs; rst forces the INIT condition at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_INIT;
            clr_cnt     <= '0;
            instr       <= NOP_WORD;
            instr_valid <= 1'b0;
            ready       <= 1'b0;
            ld_err      <= 1'b0;
        end else begin
            state       <= state_nxt;
            clr_cnt     <= clr_cnt_nxt;
            instr       <= instr_nxt;
            instr_valid <= instr_valid_nxt;
            ready       <= ready_nxt;
            ld_err      <= ld_err_nxt;
        end
    end

    // Next-state logic: the sweep counter walks every word once, then RUN is terminal.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            ST_INIT: begin
                if (clr_cnt == ADDR_W'(LAST_IDX)) begin
                    state_nxt = ST_RUN;
                end else begin
                    clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // Output logic: fetch priority, load acceptance/rejection and memory write port.
    always_comb begin
        instr_nxt       = instr;
        instr_valid_nxt = instr_valid;
        ready_nxt       = (state_nxt == ST_RUN);
        ld_err_nxt      = 1'b0;
        mem_we          = 1'b0;
        mem_waddr       = ld_addr;
        mem_wdata       = ld_data;
        case (state)
            ST_INIT: begin
                instr_valid_nxt = 1'b0;
                ld_err_nxt      = ld_we;
                mem_we          = 1'b1;
                mem_waddr       = clr_cnt;
                mem_wdata       = NOP_WORD;
            end
            ST_RUN: begin
                if (flush) begin
                    instr_nxt       = NOP_WORD;
                    instr_valid_nxt = 1'b0;
                end else if (!stall) begin
                    if (fetch_en) begin
                        instr_nxt       = rd_word;
                        instr_valid_nxt = 1'b1;
                    end else begin
                        instr_valid_nxt = 1'b0;
                    end
                end
                ld_err_nxt = ld_we && !ld_in_range;
                mem_we     = ld_we && ld_in_range;
            end
            default: begin
                instr_valid_nxt = 1'b0;
            end
        endcase
    end

    // Storage array: not reset, the INIT sweep rewrites it; reads are read-first.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Bench for instr_mem_sync: a DEPTH=64 instance and a DEPTH=48 instance driven
// in lockstep. The bench checks them with a vector table, directed sequences and
// random traffic, all against a cycle-level behavioural model.
module tb_instr_mem_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [5:0]  fetch_addr;
    logic        stall;
    logic        flush;
    logic        ld_we;
    logic [5:0]  ld_addr;
    logic [15:0] ld_data;

    logic [15:0] instr_a, instr_b;
    logic        valid_a, valid_b;
    logic        ready_a, ready_b;
    logic        err_a, err_b;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    instr_mem_sync #(.ADDR_W(6), .DATA_W(16), .DEPTH(64), .NOP_WORD(16'h0000)) dut_a (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
        .stall(stall), .flush(flush), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_data(ld_data), .instr(instr_a), .instr_valid(valid_a),
        .ready(ready_a), .ld_err(err_a)
    );

    instr_mem_sync #(.ADDR_W(6), .DATA_W(16), .DEPTH(48), .NOP_WORD(16'h0000)) dut_b (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
        .stall(stall), .flush(flush), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_data(ld_data), .instr(instr_b), .instr_valid(valid_b),
        .ready(ready_b), .ld_err(err_b)
    );

    // Behavioural model, one slot per instance.
    int unsigned m_depth [2] = '{64, 48};
    logic [15:0] m_mem   [2][64];
    logic [15:0] m_instr [2];
    logic        m_valid [2];
    logic        m_ready [2];
    logic        m_err   [2];
    int          m_left  [2];

    typedef struct {
        logic        fe;
        logic [5:0]  fa;
        logic        st;
        logic        fl;
        logic        we;
        logic [5:0]  la;
        logic [15:0] ld;
        logic [15:0] exp_instr;
        logic        exp_valid;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_left[k]  = int'(m_depth[k]);
            m_instr[k] = 16'h0000;
            m_valid[k] = 1'b0;
            m_ready[k] = 1'b0;
            m_err[k]   = 1'b0;
            for (int i = 0; i < 64; i++) m_mem[k][i] = 16'h0000;
        end
    endtask

    task automatic model_edge();
        logic [15:0] rd;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_left[k]  = int'(m_depth[k]);
                m_instr[k] = 16'h0000;
                m_valid[k] = 1'b0;
                m_ready[k] = 1'b0;
                m_err[k]   = 1'b0;
            end else if (m_left[k] > 0) begin
                m_err[k]   = ld_we;
                m_valid[k] = 1'b0;
                m_left[k]  = m_left[k] - 1;
                m_ready[k] = (m_left[k] == 0);
                if (m_left[k] == 0)
                    for (int i = 0; i < 64; i++) m_mem[k][i] = 16'h0000;
            end else begin
                m_err[k] = ld_we && (32'(ld_addr) >= m_depth[k]);
                rd = (32'(fetch_addr) < m_depth[k]) ? m_mem[k][fetch_addr] : 16'h0000;
                if (flush) begin
                    m_instr[k] = 16'h0000;
                    m_valid[k] = 1'b0;
                end else if (!stall) begin
                    if (fetch_en) begin
                        m_instr[k] = rd;
                        m_valid[k] = 1'b1;
                    end else begin
                        m_valid[k] = 1'b0;
                    end
                end
                if (ld_we && (32'(ld_addr) < m_depth[k])) m_mem[k][ld_addr] = ld_data;
            end
        end
    endtask

    task automatic check_models();
        chk("a.instr", 32'(instr_a), 32'(m_instr[0]));
        chk("a.valid", 32'(valid_a), 32'(m_valid[0]));
        chk("a.ready", 32'(ready_a), 32'(m_ready[0]));
        chk("a.ld_err", 32'(err_a), 32'(m_err[0]));
        chk("b.instr", 32'(instr_b), 32'(m_instr[1]));
        chk("b.valid", 32'(valid_b), 32'(m_valid[1]));
        chk("b.ready", 32'(ready_b), 32'(m_ready[1]));
        chk("b.ld_err", 32'(err_b), 32'(m_err[1]));
    endtask

    // One clock: model advances on the edge, outputs are compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_models();
    endtask

    task automatic idle();
        fetch_en = 1'b0; fetch_addr = '0; stall = 1'b0; flush = 1'b0;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    endtask

    task automatic set_vec(input vec_t v);
        fetch_en = v.fe; fetch_addr = v.fa; stall = v.st; flush = v.fl;
        ld_we = v.we; ld_addr = v.la; ld_data = v.ld;
    endtask

    initial begin
        // Load/fetch, stall/flush and read-first vectors, with results expected on instance a.
        vecs[0]  = '{1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 6'd0, 16'hB040, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 6'd1, 16'hB210, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 6'd2, 16'hC250, 16'h0000, 1'b0};
        vecs[3]  = '{1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0000, 16'hB040, 1'b1};
        vecs[4]  = '{1'b1, 6'd1, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0000, 16'hB210, 1'b1};
        vecs[5]  = '{1'b1, 6'd2, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0000, 16'hC250, 1'b1};
        vecs[6]  = '{1'b1, 6'd1, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0000, 16'hB210, 1'b1};
        vecs[7]  = '{1'b1, 6'd2, 1'b1, 1'b0, 1'b0, 6'd0, 16'h0000, 16'hB210, 1'b1};
        vecs[8]  = '{1'b1, 6'd2, 1'b1, 1'b0, 1'b0, 6'd0, 16'h0000, 16'hB210, 1'b1};
        vecs[9]  = '{1'b1, 6'd2, 1'b1, 1'b0, 1'b0, 6'd0, 16'h0000, 16'hB210, 1'b1};
        vecs[10] = '{1'b1, 6'd2, 1'b1, 1'b1, 1'b0, 6'd0, 16'h0000, 16'h0000, 1'b0};
        vecs[11] = '{1'b1, 6'd3, 1'b0, 1'b0, 1'b1, 6'd3, 16'h1234, 16'h0000, 1'b1};
        vecs[12] = '{1'b1, 6'd3, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0000, 16'h1234, 1'b1};

        rst = 1'b1;
        idle();
        model_reset();

        // Reset state.
        @(negedge clk);
        check_models();
        chk("rst.instr", 32'(instr_a), 32'h0);
        chk("rst.ready", 32'(ready_a), 32'h0);
        step();

        // Init sweep with fetch requests held high.
        rst = 1'b0;
        fetch_en = 1'b1; fetch_addr = 6'd5;
        for (int i = 1; i <= 64; i++) begin
            step();
            chk($sformatf("init.ready[%0d]", i), 32'(ready_a), (i == 64) ? 32'h1 : 32'h0);
            chk($sformatf("init.valid[%0d]", i), 32'(valid_a), 32'h0);
        end
        step();
        chk("init.fetch5.instr", 32'(instr_a), 32'h0);
        chk("init.fetch5.valid", 32'(valid_a), 32'h1);

        // Vector table.
        for (int i = 0; i < 13; i++) begin
            set_vec(vecs[i]);
            step();
            chk($sformatf("vec[%0d].instr", i), 32'(instr_a), 32'(vecs[i].exp_instr));
            chk($sformatf("vec[%0d].valid", i), 32'(valid_a), 32'(vecs[i].exp_valid));
        end

        // Out-of-range load on the 48-word instance.
        idle();
        ld_we = 1'b1; ld_addr = 6'd50; ld_data = 16'hABCD;
        step();
        chk("oor.err_b", 32'(err_b), 32'h1);
        chk("oor.err_a", 32'(err_a), 32'h0);
        idle();
        step();
        chk("oor.err_b_drop", 32'(err_b), 32'h0);
        fetch_en = 1'b1; fetch_addr = 6'd50;
        step();
        chk("oor.fetch50_b", 32'(instr_b), 32'h0);
        chk("oor.valid50_b", 32'(valid_b), 32'h1);
        chk("oor.fetch50_a", 32'(instr_a), 32'hABCD);
        fetch_addr = 6'd2;
        step();
        chk("oor.alias2_b", 32'(instr_b), 32'hC250);

        // Asynchronous reset between edges while a fetch is valid.
        fetch_addr = 6'd0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst.valid_a", 32'(valid_a), 32'h0);
        chk("arst.ready_a", 32'(ready_a), 32'h0);
        chk("arst.valid_b", 32'(valid_b), 32'h0);
        chk("arst.ready_b", 32'(ready_b), 32'h0);
        model_reset();
        @(negedge clk);
        check_models();

        // Load attempted during INIT is rejected and does not stick.
        rst = 1'b0;
        idle();
        ld_we = 1'b1; ld_addr = 6'd7; ld_data = 16'h5555;
        fetch_en = 1'b1; fetch_addr = 6'd7;
        step();
        chk("initld.err", 32'(err_a), 32'h1);
        chk("initld.valid", 32'(valid_a), 32'h0);
        idle();
        step();
        chk("initld.err_drop", 32'(err_a), 32'h0);
        for (int i = 0; i < 62; i++) step();
        chk("rerun.ready", 32'(ready_a), 32'h1);
        fetch_en = 1'b1; fetch_addr = 6'd7;
        step();
        chk("rerun.fetch7", 32'(instr_a), 32'h0);
        fetch_addr = 6'd0;
        step();
        chk("rerun.fetch0", 32'(instr_a), 32'h0);
        chk("rerun.valid0", 32'(valid_a), 32'h1);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            fetch_en   = 1'($urandom_range(0, 1));
            fetch_addr = 6'($urandom_range(0, 63));
            stall      = ($urandom_range(0, 7) == 0);
            flush      = ($urandom_range(0, 9) == 0);
            ld_we      = ($urandom_range(0, 2) == 0);
            ld_addr    = 6'($urandom_range(0, 63));
            ld_data    = 16'($urandom());
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
